// File: rtl/rename_free_list_pkg.sv
// rtl/rename_free_list_pkg.sv - shared sizes, types and pointer helper for the rename free list
// Contents: register-file sizing localparams, preg/count/pointer typedefs, ptr_add (mod-DEPTH add).
package rename_free_list_pkg;

  localparam int PHY_REG_NUM  = 64;
  localparam int ARCH_REG_NUM = 32;
  localparam int ALLOC_WIDTH  = 4;
  localparam int COMMIT_WIDTH = 4;

  localparam int DEPTH     = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int PREG_W    = $clog2(PHY_REG_NUM);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ALLOC_CW  = $clog2(ALLOC_WIDTH + 1);
  localparam int COMMIT_CW = $clog2(COMMIT_WIDTH + 1);

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [ALLOC_CW-1:0]  alloc_cnt_t;
  typedef logic [COMMIT_CW-1:0] commit_cnt_t;

  // DEPTH need not be a power of two, so wrap by compare-and-subtract.
  // base < DEPTH and inc <= DEPTH keep the sum below 2*DEPTH, so one
  // subtraction is always enough.
  function automatic ptr_t ptr_add(ptr_t base, logic [PTR_W:0] inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/rename_free_list_if.sv
// rtl/rename_free_list_if.sv - rename/commit side bundle of the physical-register free list
// master: rename + ROB commit side (drives requests, frees, commits, flush)
// slave : free list (drives grant, allocated pregs and counters)
interface rename_free_list_if;
  import rename_free_list_pkg::*;

  logic                                flush_i;
  logic [ALLOC_WIDTH-1:0]              alloc_req_i;
  logic                                alloc_ready_o;
  preg_t [ALLOC_WIDTH-1:0]             alloc_preg_o;
  logic [COMMIT_WIDTH-1:0]             commit_alloc_i;
  logic [COMMIT_WIDTH-1:0]             free_valid_i;
  preg_t [COMMIT_WIDTH-1:0]            free_preg_i;
  cnt_t                                spec_cnt_o;
  cnt_t                                arch_cnt_o;

  modport master (
    output flush_i, alloc_req_i, commit_alloc_i, free_valid_i, free_preg_i,
    input  alloc_ready_o, alloc_preg_o, spec_cnt_o, arch_cnt_o
  );

  modport slave (
    input  flush_i, alloc_req_i, commit_alloc_i, free_valid_i, free_preg_i,
    output alloc_ready_o, alloc_preg_o, spec_cnt_o, arch_cnt_o
  );

endinterface

// File: rtl/rename_free_list_lane_prefix_count.sv
// rtl/rename_free_list_lane_prefix_count.sv - lane popcount with per-lane exclusive prefix ranks
// lanes in : per-lane valid bits
// count out: number of set lanes
// rank  out: for each lane, number of set lanes strictly below it
module lane_prefix_count #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         lanes,
  output logic [CW-1:0]            count,
  output logic [WIDTH-1:0][CW-1:0] rank
);

  logic [CW-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rank[k] = acc;
      acc     = acc + CW'(lanes[k]);
    end
    count = acc;
  end

endmodule

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - speculative physical-register free list with one-cycle flush recovery
// clk : clock, all state on rising edge
// rst : synchronous active-high reset
// fl  : rename_free_list_if.slave (alloc request/grant/pregs, commit, free, flush, counters)
module rename_free_list
  import rename_free_list_pkg::*;
(
  input logic              clk,
  input logic              rst,
  rename_free_list_if.slave fl
);

  preg_t mem [DEPTH];

  ptr_t spec_head, arch_head, tail;
  cnt_t spec_cnt, arch_cnt;
  ptr_t spec_head_n, arch_head_n, tail_n;
  cnt_t spec_cnt_n, arch_cnt_n;

  alloc_cnt_t                              alloc_n;
  logic [ALLOC_WIDTH-1:0][ALLOC_CW-1:0]    alloc_rank;
  commit_cnt_t                             free_m;
  logic [COMMIT_WIDTH-1:0][COMMIT_CW-1:0]  free_rank;
  commit_cnt_t                             commit_c;
  logic [COMMIT_WIDTH-1:0][COMMIT_CW-1:0]  commit_rank_unused;

  logic                    grant;
  preg_t [ALLOC_WIDTH-1:0] alloc_preg;

  lane_prefix_count #(.WIDTH(ALLOC_WIDTH)) u_alloc_cnt (
    .lanes (fl.alloc_req_i),
    .count (alloc_n),
    .rank  (alloc_rank)
  );

  lane_prefix_count #(.WIDTH(COMMIT_WIDTH)) u_free_cnt (
    .lanes (fl.free_valid_i),
    .count (free_m),
    .rank  (free_rank)
  );

  lane_prefix_count #(.WIDTH(COMMIT_WIDTH)) u_commit_cnt (
    .lanes (fl.commit_alloc_i),
    .count (commit_c),
    .rank  (commit_rank_unused)
  );

  // Grant only looks at registered spec_cnt: same-cycle frees are not
  // bypassed, so the grant path never depends on free_valid_i.
  assign grant = !fl.flush_i && (cnt_t'(alloc_n) <= spec_cnt);

  always_comb begin
    alloc_preg = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (fl.alloc_req_i[k])
        alloc_preg[k] = mem[ptr_add(spec_head, (PTR_W+1)'(alloc_rank[k]))];
    end
  end

  assign fl.alloc_ready_o = grant;
  assign fl.alloc_preg_o  = alloc_preg;
  assign fl.spec_cnt_o    = spec_cnt;
  assign fl.arch_cnt_o    = arch_cnt;

  // Flush copies the architectural state including this cycle's commit and
  // free, so speculative state is whole again on the next edge.
  always_comb begin
    arch_head_n = ptr_add(arch_head, (PTR_W+1)'(commit_c));
    arch_cnt_n  = arch_cnt + cnt_t'(free_m) - cnt_t'(commit_c);
    tail_n      = ptr_add(tail, (PTR_W+1)'(free_m));
    spec_head_n = spec_head;
    spec_cnt_n  = spec_cnt + cnt_t'(free_m);
    if (fl.flush_i) begin
      spec_head_n = arch_head_n;
      spec_cnt_n  = arch_cnt_n;
    end else if (grant) begin
      spec_head_n = ptr_add(spec_head, (PTR_W+1)'(alloc_n));
      spec_cnt_n  = spec_cnt + cnt_t'(free_m) - cnt_t'(alloc_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= '0;
      spec_cnt  <= cnt_t'(DEPTH);
      arch_cnt  <= cnt_t'(DEPTH);
      for (int i = 0; i < DEPTH; i++) mem[i] <= preg_t'(ARCH_REG_NUM + i);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (fl.free_valid_i[j])
          mem[ptr_add(tail, (PTR_W+1)'(free_rank[j]))] <= fl.free_preg_i[j];
      end
      spec_head <= spec_head_n;
      arch_head <= arch_head_n;
      tail      <= tail_n;
      spec_cnt  <= spec_cnt_n;
      arch_cnt  <= arch_cnt_n;
    end
  end

  a_free_overflow: assert property (@(posedge clk) disable iff (rst)
    int'(spec_cnt) + int'(free_m) <= DEPTH);
  a_commit_underflow: assert property (@(posedge clk) disable iff (rst)
    int'(commit_c) <= int'(arch_cnt));
  a_cnt_order: assert property (@(posedge clk) disable iff (rst)
    (spec_cnt <= arch_cnt) && (int'(arch_cnt) <= DEPTH));

endmodule

// File: tb/tb_rename_free_list.sv
// tb/tb_rename_free_list.sv - directed and scoreboarded bench for rename_free_list
module tb_rename_free_list;
  import rename_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_free_list_if fl_if();

  rename_free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    fl_if.flush_i        = 1'b0;
    fl_if.alloc_req_i    = '0;
    fl_if.commit_alloc_i = '0;
    fl_if.free_valid_i   = '0;
    fl_if.free_preg_i    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int preg_of(int k);
    return int'(fl_if.alloc_preg_o[k]);
  endfunction

  preg_t       fl_q[$];
  preg_t       owned_q[$];
  int          spec_off;
  logic [3:0]  req, cm, fm;
  preg_t       fpreg [COMMIT_WIDTH];
  logic        fl_flush;
  logic        exp_ready;
  int          n, r, idx;

  initial begin
    rst = 1'b1;
    set_idle();

    // Reset state, full list grants all four lanes
    do_reset();
    check_eq("rst_spec_cnt", int'(fl_if.spec_cnt_o), 32);
    check_eq("rst_arch_cnt", int'(fl_if.arch_cnt_o), 32);
    fl_if.alloc_req_i = 4'b1111;
    #1;
    check_eq("t1_ready", int'(fl_if.alloc_ready_o), 1);
    for (int k = 0; k < 4; k++) check_eq("t1_preg", preg_of(k), 32 + k);
    tick();
    set_idle();
    check_eq("t1_spec_cnt", int'(fl_if.spec_cnt_o), 28);
    check_eq("t1_arch_cnt", int'(fl_if.arch_cnt_o), 32);

    // Sparse lanes
    do_reset();
    fl_if.alloc_req_i = 4'b1010;
    #1;
    check_eq("t2_ready", int'(fl_if.alloc_ready_o), 1);
    check_eq("t2_lane0", preg_of(0), 0);
    check_eq("t2_lane1", preg_of(1), 32);
    check_eq("t2_lane2", preg_of(2), 0);
    check_eq("t2_lane3", preg_of(3), 33);
    tick();
    fl_if.alloc_req_i = 4'b0001;
    #1;
    check_eq("t2_next_lane0", preg_of(0), 34);
    check_eq("t2_spec_cnt", int'(fl_if.spec_cnt_o), 30);
    tick();
    set_idle();

    // Drain to 2, refused request with same-cycle free, then wrap
    do_reset();
    repeat (7) begin
      fl_if.alloc_req_i = 4'b1111;
      tick();
    end
    fl_if.alloc_req_i = 4'b0011;
    tick();
    set_idle();
    check_eq("t3_drain_spec", int'(fl_if.spec_cnt_o), 2);
    fl_if.commit_alloc_i = 4'b1111;
    tick();
    set_idle();
    check_eq("t3_commit_arch", int'(fl_if.arch_cnt_o), 28);
    fl_if.alloc_req_i    = 4'b0111;
    fl_if.free_valid_i   = 4'b0011;
    fl_if.free_preg_i[0] = 6'd5;
    fl_if.free_preg_i[1] = 6'd6;
    #1;
    check_eq("t3_empty_ready", int'(fl_if.alloc_ready_o), 0);
    tick();
    set_idle();
    check_eq("t3_free_spec", int'(fl_if.spec_cnt_o), 4);
    check_eq("t3_free_arch", int'(fl_if.arch_cnt_o), 30);
    fl_if.alloc_req_i = 4'b0111;
    #1;
    check_eq("t3_ready3", int'(fl_if.alloc_ready_o), 1);
    fl_if.alloc_req_i = 4'b1111;
    #1;
    check_eq("t3_ready4", int'(fl_if.alloc_ready_o), 1);
    check_eq("t3_wrap0", preg_of(0), 62);
    check_eq("t3_wrap1", preg_of(1), 63);
    check_eq("t3_wrap2", preg_of(2), 5);
    check_eq("t3_wrap3", preg_of(3), 6);
    tick();
    set_idle();
    check_eq("t3_zero_spec", int'(fl_if.spec_cnt_o), 0);
    fl_if.alloc_req_i = 4'b0001;
    #1;
    check_eq("t3_zero_ready", int'(fl_if.alloc_ready_o), 0);
    set_idle();

    // Flush recovery with same-cycle commit and free
    do_reset();
    fl_if.alloc_req_i = 4'b1111;
    tick();
    tick();
    set_idle();
    fl_if.commit_alloc_i = 4'b0111;
    tick();
    set_idle();
    check_eq("t4_arch_pre", int'(fl_if.arch_cnt_o), 29);
    check_eq("t4_spec_pre", int'(fl_if.spec_cnt_o), 24);
    fl_if.flush_i        = 1'b1;
    fl_if.alloc_req_i    = 4'b1111;
    fl_if.commit_alloc_i = 4'b0001;
    fl_if.free_valid_i   = 4'b0001;
    fl_if.free_preg_i[0] = 6'd7;
    #1;
    check_eq("t4_flush_ready", int'(fl_if.alloc_ready_o), 0);
    tick();
    set_idle();
    check_eq("t4_spec_post", int'(fl_if.spec_cnt_o), 29);
    check_eq("t4_arch_post", int'(fl_if.arch_cnt_o), 29);
    fl_if.alloc_req_i = 4'b0001;
    #1;
    check_eq("t4_ready_post", int'(fl_if.alloc_ready_o), 1);
    check_eq("t4_head_preg", preg_of(0), 36);
    tick();
    set_idle();
    check_eq("t4_spec_after", int'(fl_if.spec_cnt_o), 28);

    // Reset mid-operation dominates flush, frees and commits
    rst                  = 1'b1;
    fl_if.flush_i        = 1'b1;
    fl_if.alloc_req_i    = 4'b1111;
    fl_if.commit_alloc_i = 4'b0001;
    fl_if.free_valid_i   = 4'b0001;
    fl_if.free_preg_i[0] = 6'd9;
    tick();
    rst = 1'b0;
    set_idle();
    check_eq("t5_spec", int'(fl_if.spec_cnt_o), 32);
    check_eq("t5_arch", int'(fl_if.arch_cnt_o), 32);
    fl_if.alloc_req_i = 4'b0001;
    #1;
    check_eq("t5_preg", preg_of(0), 32);
    set_idle();

    // Random run against a queue model: fl_q holds architecturally free
    // pregs in order, spec_off of them are speculatively handed out.
    do_reset();
    fl_q.delete();
    owned_q.delete();
    for (int i = 0; i < DEPTH; i++) fl_q.push_back(preg_t'(ARCH_REG_NUM + i));
    for (int i = 0; i < ARCH_REG_NUM; i++) owned_q.push_back(preg_t'(i));
    spec_off = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req      = 4'($urandom_range(0, 15));
      fl_flush = ($urandom_range(0, 15) == 0);
      cm       = 4'($urandom_range(0, 15));
      while ($countones(cm) > spec_off) cm = cm & (cm - 4'd1);
      fm       = 4'($urandom_range(0, 15));
      while ($countones(fm) > DEPTH - fl_q.size()) fm = fm & (fm - 4'd1);
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        fpreg[j] = '0;
        if (fm[j]) begin
          idx      = $urandom_range(0, owned_q.size() - 1);
          fpreg[j] = owned_q[idx];
          owned_q.delete(idx);
        end
      end
      fl_if.alloc_req_i    = req;
      fl_if.flush_i        = fl_flush;
      fl_if.commit_alloc_i = cm;
      fl_if.free_valid_i   = fm;
      for (int j = 0; j < COMMIT_WIDTH; j++) fl_if.free_preg_i[j] = fpreg[j];
      #1;
      n         = $countones(req);
      exp_ready = !fl_flush && (n <= fl_q.size() - spec_off);
      check_eq("rnd_ready", int'(fl_if.alloc_ready_o), int'(exp_ready));
      if (exp_ready) begin
        r = 0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
          if (req[k]) begin
            check_eq("rnd_preg", preg_of(k), int'(fl_q[spec_off + r]));
            r++;
          end
        end
      end
      tick();
      for (int i = 0; i < $countones(cm); i++) owned_q.push_back(fl_q.pop_front());
      spec_off = spec_off - $countones(cm);
      if (exp_ready) spec_off = spec_off + n;
      for (int j = 0; j < COMMIT_WIDTH; j++) if (fm[j]) fl_q.push_back(fpreg[j]);
      if (fl_flush) spec_off = 0;
      check_eq("rnd_spec_cnt", int'(fl_if.spec_cnt_o), fl_q.size() - spec_off);
      check_eq("rnd_arch_cnt", int'(fl_if.arch_cnt_o), fl_q.size());
    end
    set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
